// File: rtl/aes128_inv_key_sched.sv
// Iterative AES-128 inverse key expansion: walks the round keys from round 10
// back to round 0, one key per accepted valid/ready transfer.
module aes128_inv_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key_in,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   round_num,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  localparam int          NK         = 4;
  localparam int          NR         = 10;
  localparam logic [7:0]  RCON_LAST  = 8'h36;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [7:0]  rcon;
  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p0, p1, p2, p3;
  logic [127:0] prev_key;
  logic        xfer;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    logic [7:0] y;
    acc = 8'h00;
    x   = a;
    y   = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return acc;
  endfunction

  // Forward S-box as multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon_step(input logic [7:0] r);
    return {1'b0, r[7:1]} ^ (r[0] ? 8'h8d : 8'h00);
  endfunction

  // Previous round key, undoing one forward expansion step.
  always_comb begin
    k0 = key_out[127:96];
    k1 = key_out[95:64];
    k2 = key_out[63:32];
    k3 = key_out[31:0];
    p3 = k3 ^ k2;
    p2 = k2 ^ k1;
    p1 = k1 ^ k0;
    p0 = k0 ^ sub_word(rot_word(p3)) ^ {rcon, 24'h000000};
    prev_key = {p0, p1, p2, p3};
  end

  assign xfer = key_valid & key_ready;
  // done marks the round-0 transfer itself, so it follows the handshake directly.
  assign done = xfer & (round_num == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_out   <= '0;
      round_num <= '0;
      rcon      <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            key_out   <= last_key_in;
            round_num <= 4'(NR);
            rcon      <= RCON_LAST;
            key_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (round_num == 4'd0) begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              key_out   <= prev_key;
              round_num <= round_num - 4'd1;
              rcon      <= rcon_step(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (NK != 4) begin : g_nk_check
    $error("only Nk=4 is supported");
  end

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Randomized bench for aes128_inv_key_sched against a forward key-expansion model.
module tb_aes128_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] last_key_in = '0;
  logic         key_ready = 1'b0;
  logic [127:0] key_out;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  aes128_inv_key_sched dut (
    .clk(clk), .rst(rst), .start(start), .last_key_in(last_key_in),
    .key_ready(key_ready), .key_out(key_out), .round_num(round_num),
    .key_valid(key_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] A1_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R9     = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0] sbox_t [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rcon_t [11] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  logic [127:0] model_rk [11];

  // Capture results of one run
  logic [127:0] cap_key [11];
  int cap_n, cap_order_bad, cap_stall_bad, cap_done_cnt, cap_done_at;
  logic cap_valid_after, cap_busy_after;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Standard forward key expansion; round r key = words 4r..4r+3.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_t[i/4], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Launches one run from IDLE and records every transfer; ends on the first IDLE cycle.
  task automatic run_capture(input logic [127:0] k10, input bit rand_ready);
    logic [127:0] prev_key;
    logic [3:0]   prev_round;
    bit           prev_stall;
    int           t;
    cap_n = 0; cap_order_bad = 0; cap_stall_bad = 0; cap_done_cnt = 0; cap_done_at = -1;
    for (int r = 0; r < 11; r++) cap_key[r] = 'x;
    prev_stall = 0; prev_key = '0; prev_round = '0;
    start = 1'b1; last_key_in = k10; key_ready = 1'b0;
    t = 0;
    while (cap_n < 11 && t < 300) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && (key_out !== prev_key || round_num !== prev_round)) cap_stall_bad++;
      if (done === 1'b1) begin
        cap_done_cnt++;
        cap_done_at = t;
      end
      if (key_valid === 1'b1 && key_ready) begin
        if (round_num !== 4'(10 - cap_n)) cap_order_bad++;
        if (round_num <= 4'd10) cap_key[round_num] = key_out;
        cap_n++;
      end
      prev_stall = (key_valid === 1'b1) && !key_ready;
      prev_key   = key_out;
      prev_round = round_num;
    end
    @(posedge clk); #1;
    key_ready = 1'b0;
    #1;
    cap_valid_after = key_valid;
    cap_busy_after  = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (key_out !== '0) begin failures++; $display("FAIL reset_key_out got=%h exp=0", key_out); end
    checks++; if (round_num !== '0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round_num); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_fips_a1();
    run_capture(A1_R10, 0);
    checks++; if (cap_n !== 11) begin failures++; $display("FAIL a1_transfers got=%0d exp=11", cap_n); end
    checks++; if (cap_order_bad !== 0) begin failures++; $display("FAIL a1_order bad=%0d exp=0", cap_order_bad); end
    checks++; if (cap_key[10] !== A1_R10) begin failures++; $display("FAIL a1_round10 got=%h exp=%h", cap_key[10], A1_R10); end
    checks++; if (cap_key[9] !== A1_R9) begin failures++; $display("FAIL a1_round9 got=%h exp=%h", cap_key[9], A1_R9); end
    checks++; if (cap_key[0] !== A1_CIPHER) begin failures++; $display("FAIL a1_round0 got=%h exp=%h", cap_key[0], A1_CIPHER); end
    checks++; if (cap_done_at !== 11) begin failures++; $display("FAIL a1_done_cycle got=%0d exp=11", cap_done_at); end
    checks++; if (cap_done_cnt !== 1) begin failures++; $display("FAIL a1_done_count got=%0d exp=1", cap_done_cnt); end
    checks++; if (cap_valid_after !== 1'b0) begin failures++; $display("FAIL a1_valid_after got=%b exp=0", cap_valid_after); end
    checks++; if (cap_busy_after !== 1'b0) begin failures++; $display("FAIL a1_busy_after got=%b exp=0", cap_busy_after); end
  endtask

  task automatic test_zero_key();
    expand('0);
    checks++; if (model_rk[10] !== ZERO_R10) begin failures++; $display("FAIL zero_model_r10 got=%h exp=%h", model_rk[10], ZERO_R10); end
    run_capture(ZERO_R10, 0);
    checks++; if (cap_n !== 11) begin failures++; $display("FAIL zero_transfers got=%0d exp=11", cap_n); end
    checks++; if (cap_key[0] !== '0) begin failures++; $display("FAIL zero_round0 got=%h exp=0", cap_key[0]); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (cap_key[r] !== model_rk[r]) begin failures++; $display("FAIL zero_round%0d got=%h exp=%h", r, cap_key[r], model_rk[r]); end
    end
  endtask

  task automatic test_backpressure();
    expand(A1_CIPHER);
    run_capture(A1_R10, 1);
    checks++; if (cap_n !== 11) begin failures++; $display("FAIL bp_transfers got=%0d exp=11", cap_n); end
    checks++; if (cap_order_bad !== 0) begin failures++; $display("FAIL bp_order bad=%0d exp=0", cap_order_bad); end
    checks++; if (cap_stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable bad=%0d exp=0", cap_stall_bad); end
    checks++; if (cap_done_cnt !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", cap_done_cnt); end
    checks++; if (cap_valid_after !== 1'b0) begin failures++; $display("FAIL bp_valid_after got=%b exp=0", cap_valid_after); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (cap_key[r] !== model_rk[r]) begin failures++; $display("FAIL bp_round%0d got=%h exp=%h", r, cap_key[r], model_rk[r]); end
    end
  endtask

  task automatic test_start_in_run();
    logic [127:0] k2_10;
    int bad;
    int t;
    expand(A1_CIPHER);
    bad = 0;
    start = 1'b1; last_key_in = A1_R10; key_ready = 1'b1;
    for (t = 1; t <= 11; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (key_valid !== 1'b1 || round_num !== 4'(11 - t) || key_out !== model_rk[11 - t]) bad++;
      if (t == 5) begin
        start = 1'b1;
        last_key_in = rand128();
      end
      if (t == 11) begin
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL sir_done got=%b exp=1", done); end
      end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL sir_sequence bad_cycles=%0d exp=0", bad); end
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL sir_idle_valid got=%b exp=0", key_valid); end
    expand(rand128());
    k2_10 = model_rk[10];
    start = 1'b1; last_key_in = k2_10;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    checks++;
    if (key_valid !== 1'b1 || round_num !== 4'd10 || key_out !== k2_10) begin
      failures++;
      $display("FAIL sir_restart got=v%b r%0d %h exp=v1 r10 %h", key_valid, round_num, key_out, k2_10);
    end
    t = 0;
    while (key_valid === 1'b1 && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL sir_drain got=%b exp=0", key_valid); end
    key_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int t;
    bit hit;
    expand(A1_CIPHER);
    hit = 0;
    start = 1'b1; last_key_in = A1_R10; key_ready = 1'b1;
    t = 0;
    while (!hit && t < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      t++;
      if (key_valid === 1'b1 && round_num === 4'd4) begin
        hit = 1;
        rst = 1'b1; start = 1'b1;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rmr_reach_round4 got=0 exp=1"); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (key_out !== '0 || round_num !== '0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rmr_outputs got=%h r%0d v%b b%b d%b exp=all zero", key_out, round_num, key_valid, busy, done);
    end
    @(posedge clk); #2;
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rmr_start_with_rst got=%b exp=0", key_valid); end
    expand(rand128());
    run_capture(model_rk[10], 0);
    checks++; if (cap_n !== 11) begin failures++; $display("FAIL rmr_transfers got=%0d exp=11", cap_n); end
    for (int r = 0; r < 11; r++) begin
      checks++;
      if (cap_key[r] !== model_rk[r]) begin failures++; $display("FAIL rmr_round%0d got=%h exp=%h", r, cap_key[r], model_rk[r]); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      expand(rand128());
      run_capture(model_rk[10], (n % 4) == 3);
      checks++;
      if (cap_n !== 11 || cap_order_bad !== 0 || cap_done_cnt !== 1) begin
        failures++;
        $display("FAIL rand%0d_handshake n=%0d order_bad=%0d done=%0d exp=11/0/1", n, cap_n, cap_order_bad, cap_done_cnt);
      end
      for (int r = 0; r < 11; r++) begin
        checks++;
        if (cap_key[r] !== model_rk[r]) begin
          failures++;
          $display("FAIL rand%0d_round%0d got=%h exp=%h", n, r, cap_key[r], model_rk[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips_a1();
    test_zero_key();
    test_backpressure();
    test_start_in_run();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
